// File: rtl/dual_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_mem_pkg
// Purpose  : Shared widths, client ids and the in-flight read tag type used by
//            the dual_mem arbiter and its round-robin sub-arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dual_mem_pkg;

    localparam int unsigned c_default_addr_w = 32;
    localparam int unsigned c_default_data_w = 32;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    // Bypass payload is carried at the package data width.
    typedef struct packed {
        logic                        valid;
        logic                        owner;
        logic                        bypass;
        logic [c_default_data_w-1:0] bypass_data;
    } rd_tag_t;

    function automatic logic other_client(input logic client);
        return ~client;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin arbiter with a combinational grant and
//            a registered tie-break pointer (synchronous active-high reset).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dual_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       last
);

    // r_prio_q names the client that wins a tie; the last-granted client is
    // always its complement, so a tie goes to the client other than last.
    logic       r_prio_q;
    logic       w_prio_d;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_prio_q == CLIENT0) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        w_prio_d = r_prio_q;
        if (w_gnt[0]) begin
            w_prio_d = CLIENT1;
        end else if (w_gnt[1]) begin
            w_prio_d = CLIENT0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_q <= CLIENT0;
        end else begin
            r_prio_q <= w_prio_d;
        end
    end

    assign gnt  = w_gnt;
    assign last = other_client(r_prio_q);

endmodule
`default_nettype wire

// File: rtl/dual_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dual_mem_arbiter
// Purpose  : Shares one dual_mem (separate write/read ports) between two
//            clients with independent round-robin arbitration per port and
//            tagged, fixed-latency read return routing.
//            Optional: DUAL_MEM_ARB_RAW_BYPASS_EN forwards same-cycle
//            same-address write data to the returning read.
// Revision : 1.0 - initial release
// ============================================================================
module dual_mem_arbiter
    import dual_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = c_default_addr_w,
    parameter int unsigned DATA_W = c_default_data_w,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c0_wr_req,
    input  logic [ADDR_W-1:0] c0_wr_addr,
    input  logic [DATA_W-1:0] c0_wr_data,
    output logic              c0_wr_gnt,
    input  logic              c1_wr_req,
    input  logic [ADDR_W-1:0] c1_wr_addr,
    input  logic [DATA_W-1:0] c1_wr_data,
    output logic              c1_wr_gnt,

    input  logic              c0_rd_req,
    input  logic [ADDR_W-1:0] c0_rd_addr,
    output logic              c0_rd_gnt,
    output logic              c0_rd_valid,
    output logic [DATA_W-1:0] c0_rd_data,
    input  logic              c1_rd_req,
    input  logic [ADDR_W-1:0] c1_rd_addr,
    output logic              c1_rd_gnt,
    output logic              c1_rd_valid,
    output logic [DATA_W-1:0] c1_rd_data,

    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_out
);

    localparam int unsigned c_tail = RD_LAT - 1;

    logic [1:0] w_wr_gnt;
    logic [1:0] w_rd_gnt;
    logic       w_wr_last;
    logic       w_rd_last;

    rr_arb2 u_wr_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({c1_wr_req, c0_wr_req}),
        .gnt  (w_wr_gnt),
        .last (w_wr_last)
    );

    rr_arb2 u_rd_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({c1_rd_req, c0_rd_req}),
        .gnt  (w_rd_gnt),
        .last (w_rd_last)
    );

    assign c0_wr_gnt = w_wr_gnt[0];
    assign c1_wr_gnt = w_wr_gnt[1];
    assign c0_rd_gnt = w_rd_gnt[0];
    assign c1_rd_gnt = w_rd_gnt[1];

    logic              r_mem_write_en_q,   w_mem_write_en_d;
    logic [ADDR_W-1:0] r_mem_write_addr_q, w_mem_write_addr_d;
    logic [DATA_W-1:0] r_mem_write_data_q, w_mem_write_data_d;
    logic              r_mem_read_en_q,    w_mem_read_en_d;
    logic [ADDR_W-1:0] r_mem_read_addr_q,  w_mem_read_addr_d;

    always_comb begin
        w_mem_write_en_d   = |w_wr_gnt;
        w_mem_write_addr_d = r_mem_write_addr_q;
        w_mem_write_data_d = r_mem_write_data_q;
        if (w_wr_gnt[1]) begin
            w_mem_write_addr_d = c1_wr_addr;
            w_mem_write_data_d = c1_wr_data;
        end else if (w_wr_gnt[0]) begin
            w_mem_write_addr_d = c0_wr_addr;
            w_mem_write_data_d = c0_wr_data;
        end

        w_mem_read_en_d   = |w_rd_gnt;
        w_mem_read_addr_d = r_mem_read_addr_q;
        if (w_rd_gnt[1]) begin
            w_mem_read_addr_d = c1_rd_addr;
        end else if (w_rd_gnt[0]) begin
            w_mem_read_addr_d = c0_rd_addr;
        end
    end

    // Tag stages 0..RD_LAT-1 track the memory access; the per-client valid
    // flops form the final stage, giving RD_LAT+1 cycles grant-to-valid.
    rd_tag_t           r_tag_q [RD_LAT];
    rd_tag_t           w_tag_d [RD_LAT];
    rd_tag_t           w_new_tag;
    rd_tag_t           w_ret_tag;
    logic [DATA_W-1:0] w_ret_data;
    logic [1:0]        r_rd_valid_q, w_rd_valid_d;
    logic [DATA_W-1:0] r_rd_data0_q, w_rd_data0_d;
    logic [DATA_W-1:0] r_rd_data1_q, w_rd_data1_d;

    always_comb begin
        w_new_tag       = '0;
        w_new_tag.valid = |w_rd_gnt;
        w_new_tag.owner = w_rd_gnt[1] ? CLIENT1 : CLIENT0;
`ifdef DUAL_MEM_ARB_RAW_BYPASS_EN
        // Both ports issuing next cycle to one address: memory returns stale
        // data, so the write value rides along with the tag.
        w_new_tag.bypass      = (|w_rd_gnt) && (|w_wr_gnt)
                              && (w_mem_read_addr_d == w_mem_write_addr_d);
        w_new_tag.bypass_data = c_default_data_w'(w_mem_write_data_d);
`endif
        w_tag_d[0] = w_new_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            w_tag_d[i] = r_tag_q[i-1];
        end
    end

    always_comb begin
        w_ret_tag  = r_tag_q[c_tail];
        w_ret_data = mem_read_out;
`ifdef DUAL_MEM_ARB_RAW_BYPASS_EN
        if (w_ret_tag.bypass) begin
            w_ret_data = DATA_W'(w_ret_tag.bypass_data);
        end
`endif
        w_rd_valid_d = 2'b00;
        w_rd_data0_d = r_rd_data0_q;
        w_rd_data1_d = r_rd_data1_q;
        if (w_ret_tag.valid) begin
            if (w_ret_tag.owner == CLIENT1) begin
                w_rd_valid_d[1] = 1'b1;
                w_rd_data1_d    = w_ret_data;
            end else begin
                w_rd_valid_d[0] = 1'b1;
                w_rd_data0_d    = w_ret_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_write_en_q   <= 1'b0;
            r_mem_write_addr_q <= '0;
            r_mem_write_data_q <= '0;
            r_mem_read_en_q    <= 1'b0;
            r_mem_read_addr_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_q[i] <= '0;
            end
            r_rd_valid_q <= 2'b00;
            r_rd_data0_q <= '0;
            r_rd_data1_q <= '0;
        end else begin
            r_mem_write_en_q   <= w_mem_write_en_d;
            r_mem_write_addr_q <= w_mem_write_addr_d;
            r_mem_write_data_q <= w_mem_write_data_d;
            r_mem_read_en_q    <= w_mem_read_en_d;
            r_mem_read_addr_q  <= w_mem_read_addr_d;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_q[i] <= w_tag_d[i];
            end
            r_rd_valid_q <= w_rd_valid_d;
            r_rd_data0_q <= w_rd_data0_d;
            r_rd_data1_q <= w_rd_data1_d;
        end
    end

    assign mem_write_en   = r_mem_write_en_q;
    assign mem_write_addr = r_mem_write_addr_q;
    assign mem_write_data = r_mem_write_data_q;
    assign mem_read_en    = r_mem_read_en_q;
    assign mem_read_addr  = r_mem_read_addr_q;

    // Valid is masked while reset is held so no pulse leaks before the clear.
    assign c0_rd_valid = r_rd_valid_q[0] & ~rst;
    assign c1_rd_valid = r_rd_valid_q[1] & ~rst;
    assign c0_rd_data  = r_rd_data0_q;
    assign c1_rd_data  = r_rd_data1_q;

    logic w_unused_last;
    assign w_unused_last = w_wr_last ^ w_rd_last;

`ifndef DUAL_MEM_ARB_RAW_BYPASS_EN
    logic w_unused_bypass;
    assign w_unused_bypass = ^{w_ret_tag.bypass, w_ret_tag.bypass_data};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_mem_arbiter
// Purpose  : Self-checking bench for dual_mem_arbiter: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_mem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          wr_req  [2];
    logic [AW-1:0] wr_addr [2];
    logic [DW-1:0] wr_data [2];
    logic          rd_req  [2];
    logic [AW-1:0] rd_addr [2];

    logic          c0_wr_gnt, c1_wr_gnt, c0_rd_gnt, c1_rd_gnt;
    logic          c0_rd_valid, c1_rd_valid;
    logic [DW-1:0] c0_rd_data, c1_rd_data;
    logic          mem_write_en, mem_read_en;
    logic [AW-1:0] mem_write_addr, mem_read_addr;
    logic [DW-1:0] mem_write_data, mem_read_out;

    dual_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .c0_wr_req      (wr_req[0]),
        .c0_wr_addr     (wr_addr[0]),
        .c0_wr_data     (wr_data[0]),
        .c0_wr_gnt      (c0_wr_gnt),
        .c1_wr_req      (wr_req[1]),
        .c1_wr_addr     (wr_addr[1]),
        .c1_wr_data     (wr_data[1]),
        .c1_wr_gnt      (c1_wr_gnt),
        .c0_rd_req      (rd_req[0]),
        .c0_rd_addr     (rd_addr[0]),
        .c0_rd_gnt      (c0_rd_gnt),
        .c0_rd_valid    (c0_rd_valid),
        .c0_rd_data     (c0_rd_data),
        .c1_rd_req      (rd_req[1]),
        .c1_rd_addr     (rd_addr[1]),
        .c1_rd_gnt      (c1_rd_gnt),
        .c1_rd_valid    (c1_rd_valid),
        .c1_rd_data     (c1_rd_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_out   (mem_read_out)
    );

    // dual_mem stand-in: data for the registered read address is visible
    // RD_LAT (=1) cycle after the issue edge; writes land on the next edge.
    logic [DW-1:0] env_mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= DW'(i) + 32'd1000;
        end else if (mem_write_en) begin
            env_mem[mem_write_addr[3:0]] <= mem_write_data;
        end
    end
    assign mem_read_out = env_mem[mem_read_addr[3:0]];

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          owner;
        logic [31:0] data;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] model_mem [16];
    int          wr_last_m, rd_last_m;
    logic        exp_mwe, exp_mre;
    logic [31:0] exp_mwa, exp_mwd, exp_mra;
    logic [31:0] exp_rdd [2];
    int          cyc, last_wg, last_rg;
    int          checks = 0;
    int          failures = 0;

    logic        obs_mwe, obs_mre;
    logic [31:0] obs_mwa, obs_mwd, obs_mra;
    logic [1:0]  hist_wg  [4096];
    logic [1:0]  hist_rg  [4096];
    logic [1:0]  hist_rdv [4096];
    logic [31:0] hist_rdd0[4096];
    logic [31:0] hist_rdd1[4096];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        wr_last_m = -1;
        rd_last_m = -1;
        exp_mwe = 0; exp_mwa = 0; exp_mwd = 0;
        exp_mre = 0; exp_mra = 0;
        exp_rdd[0] = 0; exp_rdd[1] = 0;
        ret_q.delete();
        for (int i = 0; i < 16; i++) model_mem[i] = 32'(i) + 32'd1000;
    endtask

    task automatic step();
        int          wg, rg;
        bit          due_v [2];
        logic [31:0] rdata;
        ret_t        ent;
        @(negedge clk);
        due_v[0] = 0;
        due_v[1] = 0;
        while (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            ent = ret_q.pop_front();
            due_v[ent.owner] = 1'b1;
            exp_rdd[ent.owner] = ent.data;
        end
        wg = rst ? -1 : pick(wr_req[0], wr_req[1], wr_last_m);
        rg = rst ? -1 : pick(rd_req[0], rd_req[1], rd_last_m);

        check_val("wr_gnt", {c1_wr_gnt, c0_wr_gnt}, {wg == 1, wg == 0});
        check_val("rd_gnt", {c1_rd_gnt, c0_rd_gnt}, {rg == 1, rg == 0});
        check_val("mem_we", mem_write_en, exp_mwe);
        check_val("mem_wa", mem_write_addr, exp_mwa);
        check_val("mem_wd", mem_write_data, exp_mwd);
        check_val("mem_re", mem_read_en, exp_mre);
        check_val("mem_ra", mem_read_addr, exp_mra);
        check_val("rd_valid", {c1_rd_valid, c0_rd_valid}, {due_v[1] & ~rst, due_v[0] & ~rst});
        check_val("rd_data0", c0_rd_data, exp_rdd[0]);
        check_val("rd_data1", c1_rd_data, exp_rdd[1]);

        obs_mwe = mem_write_en; obs_mwa = mem_write_addr; obs_mwd = mem_write_data;
        obs_mre = mem_read_en;  obs_mra = mem_read_addr;
        if (cyc < 4096) begin
            hist_wg[cyc]   = {c1_wr_gnt, c0_wr_gnt};
            hist_rg[cyc]   = {c1_rd_gnt, c0_rd_gnt};
            hist_rdv[cyc]  = {c1_rd_valid, c0_rd_valid};
            hist_rdd0[cyc] = c0_rd_data;
            hist_rdd1[cyc] = c1_rd_data;
        end

        if (rst) begin
            model_reset();
        end else begin
            exp_mwe = (wg >= 0);
            if (wg >= 0) begin
                exp_mwa   = wr_addr[wg];
                exp_mwd   = wr_data[wg];
                wr_last_m = wg;
            end
            exp_mre = (rg >= 0);
            if (rg >= 0) begin
                exp_mra = rd_addr[rg];
                rdata   = model_mem[exp_mra[3:0]];
`ifdef DUAL_MEM_ARB_RAW_BYPASS_EN
                if (wg >= 0 && exp_mwa == exp_mra) rdata = exp_mwd;
`endif
                ent.due   = cyc + RD_LAT + 1;
                ent.owner = rg[0];
                ent.data  = rdata;
                ret_q.push_back(ent);
                rd_last_m = rg;
            end
            if (wg >= 0) model_mem[exp_mwa[3:0]] = exp_mwd;
        end
        last_wg = wg;
        last_rg = rg;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        for (int c = 0; c < 2; c++) begin
            wr_req[c] = 0;
            rd_req[c] = 0;
        end
    endtask

    task automatic rand_drive();
        for (int c = 0; c < 2; c++) begin
            if (!(wr_req[c] && last_wg != c && $urandom_range(9) != 0)) begin
                wr_req[c]  = ($urandom_range(9) < 6);
                wr_addr[c] = AW'($urandom_range(7));
                wr_data[c] = $urandom;
            end
            if (!(rd_req[c] && last_rg != c && $urandom_range(9) != 0)) begin
                rd_req[c]  = ($urandom_range(9) < 6);
                rd_addr[c] = AW'($urandom_range(7));
            end
        end
        rst = ($urandom_range(299) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int          g;
        logic [31:0] raw_exp;
        rst = 1;
        for (int c = 0; c < 2; c++) begin
            wr_req[c] = 0; wr_addr[c] = 0; wr_data[c] = 0;
            rd_req[c] = 0; rd_addr[c] = 0;
        end
        last_wg = -1; last_rg = -1; cyc = 0;
        @(posedge clk); #1;
        model_reset();
        step();
        step();
        rst = 0;

        // Both clients hold write requests: alternation starting at c0
        wr_req[0] = 1; wr_addr[0] = 20; wr_data[0] = 32'hA0;
        wr_req[1] = 1; wr_addr[1] = 21; wr_data[1] = 32'hA1;
        g = cyc;
        repeat (4) step();
        drop_all();
        check_val("alt0", hist_wg[g],   2'b01);
        check_val("alt1", hist_wg[g+1], 2'b10);
        check_val("alt2", hist_wg[g+2], 2'b01);
        check_val("alt3", hist_wg[g+3], 2'b10);

        // Lone c0 write addr 12 data 244
        wr_req[0] = 1; wr_addr[0] = 12; wr_data[0] = 244;
        g = cyc;
        step();
        wr_req[0] = 0;
        step();
        check_val("wr12_gnt", hist_wg[g], 2'b01);
        check_val("wr12_en", obs_mwe, 1'b1);
        check_val("wr12_addr", obs_mwa, 32'd12);
        check_val("wr12_data", obs_mwd, 32'd244);

        // c1 reads addr 12
        rd_req[1] = 1; rd_addr[1] = 12;
        g = cyc;
        step();
        rd_req[1] = 0;
        repeat (RD_LAT + 1) step();
        check_val("rd12_gnt", hist_rg[g], 2'b10);
        for (int k = 1; k <= RD_LAT; k++) check_val("rd12_early", hist_rdv[g+k], 2'b00);
        check_val("rd12_valid", hist_rdv[g+RD_LAT+1], 2'b10);
        check_val("rd12_data", hist_rdd1[g+RD_LAT+1], 32'd244);

        // Preload 5/6/7 then interleaved reads c0,c1,c0
        wr_req[0] = 1;
        for (int i = 0; i < 3; i++) begin
            wr_addr[0] = AW'(5 + i);
            wr_data[0] = DW'(50 + 10 * i);
            step();
        end
        wr_req[0] = 0;
        step();
        g = cyc;
        rd_req[0] = 1; rd_addr[0] = 5; step();
        rd_req[0] = 0; rd_req[1] = 1; rd_addr[1] = 6; step();
        rd_req[1] = 0; rd_req[0] = 1; rd_addr[0] = 7; step();
        rd_req[0] = 0;
        repeat (RD_LAT + 1) step();
        check_val("il0_valid", hist_rdv[g+RD_LAT+1], 2'b01);
        check_val("il0_data", hist_rdd0[g+RD_LAT+1], 32'd50);
        check_val("il1_valid", hist_rdv[g+RD_LAT+2], 2'b10);
        check_val("il1_data", hist_rdd1[g+RD_LAT+2], 32'd60);
        check_val("il2_valid", hist_rdv[g+RD_LAT+3], 2'b01);
        check_val("il2_data", hist_rdd0[g+RD_LAT+3], 32'd70);

        // Same-cycle write/read collision on addr 3 (old value 11)
        wr_req[0] = 1; wr_addr[0] = 3; wr_data[0] = 11;
        step();
        wr_req[0] = 0;
        step();
        wr_req[1] = 1; wr_addr[1] = 3; wr_data[1] = 99;
        rd_req[0] = 1; rd_addr[0] = 3;
        g = cyc;
        step();
        drop_all();
        repeat (RD_LAT + 1) step();
`ifdef DUAL_MEM_ARB_RAW_BYPASS_EN
        raw_exp = 32'd99;
`else
        raw_exp = 32'd11;
`endif
        check_val("raw_valid", hist_rdv[g+RD_LAT+1], 2'b01);
        check_val("raw_data", hist_rdd0[g+RD_LAT+1], raw_exp);

        // Reset one cycle after a read grant
        rd_req[0] = 1; rd_addr[0] = 5;
        g = cyc;
        step();
        rd_req[0] = 0;
        rst = 1;
        step();
        rst = 0;
        wr_req[0] = 1; wr_req[1] = 1; rd_req[0] = 1; rd_req[1] = 1;
        step();
        drop_all();
        check_val("post_rst_wgnt", hist_wg[g+2], 2'b01);
        check_val("post_rst_rgnt", hist_rg[g+2], 2'b01);
        check_val("post_rst_out", {obs_mwe, obs_mre, obs_mwa, obs_mwd, obs_mra}, '0);
        check_val("post_rst_rdd", {hist_rdd0[g+2], hist_rdd1[g+2]}, '0);
        repeat (RD_LAT + 2) step();
        for (int k = 1; k <= RD_LAT + 1; k++) check_val("rst_no_valid", hist_rdv[g+k], 2'b00);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            rand_drive();
            step();
        end
        rst = 0;
        drop_all();
        repeat (RD_LAT + 3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_mem_arbiter.md
Name: dual_mem_arbiter

Overview:
- Shares one dual_mem instance (independent write port and read port) between two requesters, client 0 and client 1.
- Runs independent round-robin arbitration on the write port and on the read port.
- Drives registered memory control signals.
- Tags each issued read and routes the returned read data back to the owning client with fixed latency.

Parameters:
- ADDR_W, 32, address width for clients and memory.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from mem_read_en sampled high to valid mem_read_out (1..4).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- c0_wr_req / c1_wr_req  input  1  write request, held until granted
- c0_wr_addr / c1_wr_addr  input  ADDR_W  write address
- c0_wr_data / c1_wr_data  input  DATA_W  write data
- c0_wr_gnt / c1_wr_gnt  output  1  combinational write grant; request accepted this cycle
- c0_rd_req / c1_rd_req  input  1  read request, held until granted
- c0_rd_addr / c1_rd_addr  input  ADDR_W  read address
- c0_rd_gnt / c1_rd_gnt  output  1  combinational read grant
- c0_rd_valid / c1_rd_valid  output  1  one-cycle pulse, read data valid
- c0_rd_data / c1_rd_data  output  DATA_W  returned read data
- mem_write_en  output  1  to dual_mem write_en
- mem_write_addr  output  ADDR_W  to dual_mem write_addr
- mem_write_data  output  DATA_W  to dual_mem write_data
- mem_read_en  output  1  to dual_mem read_en
- mem_read_addr  output  ADDR_W  to dual_mem read_addr
- mem_read_out  input  DATA_W  from dual_mem read_out

Behaviour:
- Reset: rst is synchronous and active-high; clk is the single clock. While rst is high, and on the first edge after release:
  - all grants, mem_*_en and c*_rd_valid are 0;
  - mem addr/data outputs and c*_rd_data are 0;
  - both round-robin pointers point to client 0;
  - the read tag pipeline is cleared.
- Write arbiter:
  - Only one requester: it is granted the same cycle.
  - Both requesting: grant goes to the client other than wr_last; wr_last updates on every grant.
  - At most one wr_gnt per cycle.
- Write issue: on a grant edge, mem_write_en=1, mem_write_addr and mem_write_data are registered from the winner, so they appear one cycle after the gnt cycle. Otherwise mem_write_en=0 and addr/data hold their last value.
- Read arbiter: identical rules with its own pointer rd_last. Read and write arbitration are fully independent; both ports may issue in the same cycle.
- Read issue: on a read grant edge, mem_read_en=1 and mem_read_addr is registered. A tag {valid, owner} enters an RD_LAT+1 deep shift register.
- Read return:
  - When the tag reaches the tail, the owner's rd_valid pulses for 1 cycle and its rd_data registers mem_read_out.
  - Total latency from rd_gnt cycle to rd_valid is RD_LAT+1 cycles.
  - The other client's rd_data holds its last value.
- Throughput: one read and one write per cycle sustained; back-to-back reads pipeline with no bubbles.
- Requester rule: a client dropping req before gnt is legal; the request is simply withdrawn.
- Reset mid-operation: in-flight read tags are discarded; no rd_valid occurs for reads issued before reset.
- Same-address collision: a write and a read issued in the same cycle to the same address return the old memory contents (dual_mem read-before-write), unless the optional feature is enabled.

Optional Feature:
- Macro DUAL_MEM_ARB_RAW_BYPASS_EN.
- Defined:
  - When mem_read_en and mem_write_en are high in the same cycle with equal addresses, mem_write_data is captured into the tag entry.
  - On return, rd_data takes the captured write data instead of mem_read_out.
- Undefined: no comparator or data capture; returned data is always mem_read_out.

Decomposition:
- Shared package dual_mem_pkg:
  - ADDR_W/DATA_W defaults;
  - client id constants CLIENT0=1'b0, CLIENT1=1'b1;
  - rd_tag_t struct {valid, owner, bypass, bypass_data}.
- Sub-module rr_arb2: 2-requester round-robin arbiter (req[1:0], gnt[1:0], last pointer, sync reset). Instantiated twice, once for the write port and once for the read port.

Test Plan:
- c0 write addr 12 data 244 alone -> c0_wr_gnt same cycle; next cycle mem_write_en=1, addr 12, data 244.
- c0 and c1 both hold write requests for 4 cycles after reset -> grants alternate c0,c1,c0,c1.
- After the addr-12 write, c1 reads addr 12 -> c1_rd_valid RD_LAT+1 cycles after grant with c1_rd_data=244; c0_rd_valid stays 0.
- Interleaved reads (c0 addr 5, c1 addr 6, c0 addr 7 on consecutive cycles, memory preloaded 50/60/70) -> three consecutive valid pulses routed c0=50, c1=60, c0=70.
- Same-cycle write addr 3 data 99 and read addr 3 (old 11) -> returned data 11 without the macro, 99 with DUAL_MEM_ARB_RAW_BYPASS_EN.
- rst asserted one cycle after a read grant -> no rd_valid afterwards; all outputs 0; next simultaneous request grants c0.
